// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: interrupt sequencer state encoding, cause
// codes and the handler vectors that Control's PCSrc 100/101 decode also uses.
package cpu_ctrl_pkg;

    // Sequencer states; the encoding is visible on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_TAKE    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HANDLER = 3'd4
    } irq_state_e;

    // Why the handler was entered.
    typedef enum logic {
        CAUSE_IRQ = 1'b0,
        CAUSE_EXC = 1'b1
    } cause_e;

    localparam logic [31:0] VEC_IRQ_DEFAULT   = 32'h8000_0004;
    localparam logic [31:0] VEC_EXC_DEFAULT   = 32'h8000_0008;
    localparam int          DRAIN_CYC_DEFAULT = 3;
    localparam int          MAX_WAIT_DEFAULT  = 15;

    // Handler entry address for a given cause.
    function automatic logic [31:0] cause_vector(input cause_e      cause,
                                                 input logic [31:0] vec_irq,
                                                 input logic [31:0] vec_exc);
        return (cause == CAUSE_EXC) ? vec_exc : vec_irq;
    endfunction

    // Resume address: an interrupted instruction (or a branch caught by a
    // forced entry) re-executes, a faulting instruction is skipped.
    function automatic logic [31:0] resume_pc(input cause_e      cause,
                                              input logic [31:0] pc);
        return (cause == CAUSE_EXC) ? (pc + 32'd4) : pc;
    endfunction

endpackage

// File: rtl/irq_sequencer.sv
// Interrupt/exception entry and exit sequencer for the 5-stage pipeline.
// Picks a cycle where the ID instruction can be safely abandoned, flushes
// IF/ID, redirects the PC to the handler vector and supplies the EPC for $26.
// Kernel mode is tracked until the handler returns with jr $26.
module irq_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_IRQ   = VEC_IRQ_DEFAULT,
    parameter logic [31:0] VEC_EXC   = VEC_EXC_DEFAULT,
    parameter int          DRAIN_CYC = DRAIN_CYC_DEFAULT,
    parameter int          MAX_WAIT  = MAX_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_req,
    input  logic        irq_mask,
    input  logic        illop_id,
    input  logic        id_valid,
    input  logic        branch_id,
    input  logic        stall_id,
    input  logic        eret_id,
    input  logic [31:0] pc_id,
    output logic        redirect,
    output logic [31:0] vec_out,
    output logic        flush_if,
    output logic        flush_id,
    output logic        epc_we,
    output logic [31:0] epc_out,
    output logic        in_kernel,
    output logic        double_fault,
    output logic [2:0]  state_o
);

    // The wait counter is checked one count early so that the forced entry
    // lands MAX_WAIT+1 cycles after the request, with the counter reading
    // MAX_WAIT in TAKE.
    localparam logic [3:0] WAIT_LAST  = 4'(MAX_WAIT - 1);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

    irq_state_e  state;
    cause_e      cause_q;
    logic [3:0]  wait_cnt;
    logic [3:0]  drain_cnt;

    logic        exc_pend;
    logic        irq_pend;
    logic        safe;
    logic        wait_expired;
    logic        go_take;
    cause_e      go_cause;

    // A branch must not be split from its delay successor and a bubble has
    // no meaningful PC, so only a real, non-branch, non-stalled ID qualifies.
    assign exc_pend     = illop_id;
    assign irq_pend     = irq_req & irq_mask & ~in_kernel;
    assign safe         = id_valid & ~branch_id & ~stall_id;
    assign wait_expired = (wait_cnt == WAIT_LAST);

    assign state_o = state;
    assign vec_out = redirect ? cause_vector(cause_q, VEC_IRQ, VEC_EXC) : 32'd0;

    // Decide whether this cycle enters TAKE and with which cause; an
    // exception always wins because the faulting instruction sits in ID.
    always_comb begin
        go_take  = 1'b0;
        go_cause = CAUSE_IRQ;
        case (state)
            ST_IDLE: begin
                if (exc_pend) begin
                    go_take  = 1'b1;
                    go_cause = CAUSE_EXC;
                end else if (irq_pend && safe) begin
                    go_take  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (exc_pend) begin
                    go_take  = 1'b1;
                    go_cause = CAUSE_EXC;
                end else if (irq_req && (safe || wait_expired)) begin
                    go_take  = 1'b1;
                end
            end
            default: begin
                go_take  = 1'b0;
                go_cause = CAUSE_IRQ;
            end
        endcase
    end

    // Sequencer FSM with registered pulses, EPC capture and kernel tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cause_q      <= CAUSE_IRQ;
            wait_cnt     <= 4'd0;
            drain_cnt    <= 4'd0;
            redirect     <= 1'b0;
            flush_if     <= 1'b0;
            flush_id     <= 1'b0;
            epc_we       <= 1'b0;
            epc_out      <= 32'd0;
            in_kernel    <= 1'b0;
            double_fault <= 1'b0;
        end else begin
            redirect <= go_take;
            flush_if <= go_take;
            flush_id <= go_take;
            epc_we   <= go_take;

            if (go_take) begin
                state   <= ST_TAKE;
                cause_q <= go_cause;
                epc_out <= resume_pc(go_cause, pc_id);
                if (state == ST_WAIT) begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (irq_pend) begin
                            state    <= ST_WAIT;
                            wait_cnt <= 4'd0;
                        end
                    end
                    ST_WAIT: begin
                        // A withdrawn request abandons the entry untouched.
                        if (!irq_req) begin
                            state <= ST_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 4'd1;
                        end
                    end
                    ST_TAKE: begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                        in_kernel <= 1'b1;
                    end
                    ST_DRAIN: begin
                        if (illop_id) begin
                            double_fault <= 1'b1;
                        end
                        if (drain_cnt == 4'd0) begin
                            state <= ST_HANDLER;
                        end else begin
                            drain_cnt <= drain_cnt - 4'd1;
                        end
                    end
                    ST_HANDLER: begin
                        if (illop_id) begin
                            double_fault <= 1'b1;
                        end
                        // The jr $26 itself redirects through the datapath.
                        if (eret_id && id_valid && !stall_id) begin
                            state     <= ST_IDLE;
                            in_kernel <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer with a scoreboard of expected handler
// entries (vector, EPC) checked whenever the DUT raises redirect.
module tb_irq_sequencer;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq_req = 1'b0;
    logic        irq_mask = 1'b0;
    logic        illop_id = 1'b0;
    logic        id_valid = 1'b0;
    logic        branch_id = 1'b0;
    logic        stall_id = 1'b0;
    logic        eret_id = 1'b0;
    logic [31:0] pc_id = 32'd0;
    logic        redirect;
    logic [31:0] vec_out;
    logic        flush_if;
    logic        flush_id;
    logic        epc_we;
    logic [31:0] epc_out;
    logic        in_kernel;
    logic        double_fault;
    logic [2:0]  state_o;

    typedef struct {
        logic [31:0] vec;
        logic [31:0] epc;
    } take_t;

    take_t sb[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    n_fail = 0;
    logic  prev_red = 1'b0;

    irq_sequencer dut (
        .clk(clk), .reset(reset), .irq_req(irq_req), .irq_mask(irq_mask),
        .illop_id(illop_id), .id_valid(id_valid), .branch_id(branch_id),
        .stall_id(stall_id), .eret_id(eret_id), .pc_id(pc_id),
        .redirect(redirect), .vec_out(vec_out), .flush_if(flush_if),
        .flush_id(flush_id), .epc_we(epc_we), .epc_out(epc_out),
        .in_kernel(in_kernel), .double_fault(double_fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic expect_take(input logic [31:0] v, input logic [31:0] e);
        take_t t;
        t.vec = v;
        t.epc = e;
        sb.push_back(t);
    endtask

    // One clock; outputs are sampled 1 time unit after the edge and any
    // redirect is matched against the scoreboard.
    task automatic tick;
        take_t t;
        @(posedge clk);
        #1;
        if (redirect) begin
            chkb("redirect_width", prev_red, 1'b0);
            chkb("sb_has_entry", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                t = sb.pop_front();
                chk("vec_out", vec_out, t.vec);
                chk("epc_out", epc_out, t.epc);
            end
            chkb("flush_if", flush_if, 1'b1);
            chkb("flush_id", flush_id, 1'b1);
            chkb("epc_we", epc_we, 1'b1);
        end else begin
            chkb("epc_we_quiet", epc_we, 1'b0);
        end
        prev_red = redirect;
    endtask

    // TAKE -> DRAIN x DRAIN_CYC -> HANDLER.
    task automatic drain_to_handler;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drain_state", 32'(state_o), 32'(ST_DRAIN));
            chkb("drain_kernel", in_kernel, 1'b1);
        end
        tick();
        chk("handler_state", 32'(state_o), 32'(ST_HANDLER));
    endtask

    task automatic do_eret;
        eret_id  = 1'b1;
        id_valid = 1'b1;
        stall_id = 1'b0;
        tick();
        eret_id = 1'b0;
        chk("eret_idle", 32'(state_o), 32'(ST_IDLE));
        chkb("eret_kernel", in_kernel, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_state", 32'(state_o), 32'd0);
        chkb("rst_redirect", redirect, 1'b0);
        chk("rst_vec", vec_out, 32'd0);
        chk("rst_epc", epc_out, 32'd0);
        chkb("rst_kernel", in_kernel, 1'b0);
        chkb("rst_df", double_fault, 1'b0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        irq_mask = 1'b1;
        tick();

        // Safe interrupt at pc 0x40
        irq_req  = 1'b1;
        id_valid = 1'b1;
        pc_id    = 32'h40;
        expect_take(32'h8000_0004, 32'h40);
        tick();
        chk("t1_take", 32'(state_o), 32'(ST_TAKE));
        irq_req = 1'b0;
        drain_to_handler();
        chk("t1_epc_hold", epc_out, 32'h40);

        // HANDLER ignores irq, eret blocked by stall, then eret
        irq_req = 1'b1;
        pc_id   = 32'h60;
        tick();
        chk("h_irq_ignored", 32'(state_o), 32'(ST_HANDLER));
        eret_id  = 1'b1;
        stall_id = 1'b1;
        tick();
        chk("h_eret_stalled", 32'(state_o), 32'(ST_HANDLER));
        stall_id = 1'b0;
        tick();
        eret_id = 1'b0;
        chk("h_eret_idle", 32'(state_o), 32'(ST_IDLE));
        chkb("h_eret_kernel", in_kernel, 1'b0);
        // Pending irq re-enters
        expect_take(32'h8000_0004, 32'h60);
        tick();
        chk("reenter_take", 32'(state_o), 32'(ST_TAKE));
        irq_req = 1'b0;
        drain_to_handler();

        // illop in HANDLER -> sticky double fault
        illop_id = 1'b1;
        tick();
        illop_id = 1'b0;
        chkb("df_set", double_fault, 1'b1);
        chk("df_stay_handler", 32'(state_o), 32'(ST_HANDLER));
        do_eret();
        chkb("df_after_eret", double_fault, 1'b1);

        // Interrupt blocked by branch for 2 cycles, then safe at 0x48
        irq_req   = 1'b1;
        branch_id = 1'b1;
        pc_id     = 32'h44;
        tick();
        chk("w_state1", 32'(state_o), 32'(ST_WAIT));
        tick();
        chk("w_state2", 32'(state_o), 32'(ST_WAIT));
        branch_id = 1'b0;
        pc_id     = 32'h48;
        expect_take(32'h8000_0004, 32'h48);
        tick();
        chk("w_take", 32'(state_o), 32'(ST_TAKE));
        irq_req = 1'b0;
        drain_to_handler();
        do_eret();

        // Forced entry: branch held for 16 cycles
        irq_req   = 1'b1;
        branch_id = 1'b1;
        pc_id     = 32'h80;
        tick();
        chk("f_wait", 32'(state_o), 32'(ST_WAIT));
        for (int i = 0; i < 14; i++) tick();
        chk("f_still_wait", 32'(state_o), 32'(ST_WAIT));
        pc_id = 32'hC0;
        expect_take(32'h8000_0004, 32'hC0);
        tick();
        chk("f_take", 32'(state_o), 32'(ST_TAKE));
        irq_req   = 1'b0;
        branch_id = 1'b0;
        drain_to_handler();
        do_eret();

        // Exception and interrupt together at 0x100
        illop_id = 1'b1;
        irq_req  = 1'b1;
        pc_id    = 32'h100;
        expect_take(32'h8000_0008, 32'h104);
        tick();
        chk("e_take", 32'(state_o), 32'(ST_TAKE));
        illop_id = 1'b0;
        irq_req  = 1'b0;
        drain_to_handler();
        do_eret();

        // Exception arriving while waiting
        irq_req   = 1'b1;
        branch_id = 1'b1;
        pc_id     = 32'h1F0;
        tick();
        chk("ew_wait", 32'(state_o), 32'(ST_WAIT));
        illop_id  = 1'b1;
        branch_id = 1'b0;
        pc_id     = 32'h200;
        expect_take(32'h8000_0008, 32'h204);
        tick();
        chk("ew_take", 32'(state_o), 32'(ST_TAKE));
        illop_id = 1'b0;
        irq_req  = 1'b0;
        drain_to_handler();
        do_eret();

        // Request withdrawn during WAIT
        irq_req   = 1'b1;
        branch_id = 1'b1;
        tick();
        chk("d_wait", 32'(state_o), 32'(ST_WAIT));
        irq_req = 1'b0;
        tick();
        chk("d_idle", 32'(state_o), 32'(ST_IDLE));
        chkb("d_no_redirect", redirect, 1'b0);
        branch_id = 1'b0;

        // Masked interrupt stays idle
        irq_mask = 1'b0;
        irq_req  = 1'b1;
        tick();
        chk("mask_idle", 32'(state_o), 32'(ST_IDLE));
        irq_req  = 1'b0;
        irq_mask = 1'b1;
        tick();

        // Asynchronous reset during DRAIN
        irq_req = 1'b1;
        pc_id   = 32'h300;
        expect_take(32'h8000_0004, 32'h300);
        tick();
        irq_req = 1'b0;
        tick();
        chk("r_drain", 32'(state_o), 32'(ST_DRAIN));
        chkb("r_df_before", double_fault, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_state", 32'(state_o), 32'd0);
        chkb("r_kernel", in_kernel, 1'b0);
        chkb("r_df", double_fault, 1'b0);
        chk("r_epc", epc_out, 32'd0);
        chkb("r_redirect", redirect, 1'b0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        prev_red = 1'b0;
        tick();
        chk("r_after_idle", 32'(state_o), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
